sa_ram_rwsp_param: RTL

- Parametrised two-port RAM model (one read port, one write port) for FPGA builds of the systolic-array buffers. Supersedes the fixed-size rwsp RAM models.
- Keeps the same read pipeline: the read address is registered on re, and the output is registered on ore.
- Adds generic width and depth, a reset-driven memory clear sequencer, a selectable write-first bypass on read/write collision, and an output-valid flag.

---
 rtl/sa_ram_rwsp_param.sv | 126 ++++++++++++
 1 files changed

// File: rtl/sa_ram_rwsp_param.sv
// Parametrised 1R1W RAM for the systolic-array buffers: registered read address and
// registered output, reset-driven clear sweep, optional write-first bypass, output-valid flag.
module sa_ram_rwsp_param #(
   parameter int               WIDTH          = 6,
   parameter int               DEPTH          = 128,
   parameter int               AW             = 7,
   parameter int               CLEAR_ON_RESET = 1,
   parameter logic [WIDTH-1:0] INIT_VAL       = '0,
   parameter int               BYPASS         = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [AW-1:0]    ra,
   input  logic             re,
   input  logic             ore,
   output logic [WIDTH-1:0] dout,
   output logic             dout_vld,
   input  logic [AW-1:0]    wa,
   input  logic             we,
   input  logic [WIDTH-1:0] di,
   output logic             init_done,
   input  logic [31:0]      pwrbus_ram_pd
);

   typedef enum logic {ST_INIT, ST_READY} state_t;

   localparam logic [AW:0]   DEPTH_EXT = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   logic [WIDTH-1:0] mem [DEPTH];

   state_t           state_reg, state_next;
   logic [AW-1:0]    cnt_reg;
   logic             init_done_reg;
   logic [AW-1:0]    ra_d_reg;
   logic [WIDTH-1:0] dout_reg;
   logic             dout_vld_reg;

   logic             mem_we;
   logic [AW-1:0]    mem_wa;
   logic [WIDTH-1:0] mem_wd;
   logic             wa_in_range;
   logic             ra_d_in_range;
   logic [WIDTH-1:0] rd_word;

   // The power-down bus is carried for interface compatibility only.
   logic unused_pwrbus;
   assign unused_pwrbus = ^pwrbus_ram_pd;

   assign wa_in_range   = ({1'b0, wa} < DEPTH_EXT);
   assign ra_d_in_range = ({1'b0, ra_d_reg} < DEPTH_EXT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_READY;
         cnt_reg       <= '0;
         init_done_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         if (state_reg == ST_INIT)
            cnt_reg <= cnt_reg + 1'b1;
         init_done_reg <= (state_next == ST_READY);
      end
   end

   always_comb begin
      state_next = state_reg;
      if (state_reg == ST_INIT && cnt_reg == LAST_ADDR)
         state_next = ST_READY;
   end

   // The sweep and the external write share the single array write port.
   always_comb begin
      mem_we = 1'b0;
      mem_wa = wa;
      mem_wd = di;
      case (state_reg)
         ST_INIT: begin
            mem_we = ~rst;
            mem_wa = cnt_reg;
            mem_wd = INIT_VAL;
         end
         default: begin
            mem_we = ~rst & init_done_reg & we & wa_in_range;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (mem_we)
         mem[mem_wa] <= mem_wd;
   end

   // Out-of-range addresses read as INIT_VAL even when a write targets the same address.
   always_comb begin
      rd_word = mem[ra_d_reg];
      if (!ra_d_in_range)
         rd_word = INIT_VAL;
      else if (BYPASS != 0 && we && wa == ra_d_reg)
         rd_word = di;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ra_d_reg     <= '0;
         dout_reg     <= '0;
         dout_vld_reg <= 1'b0;
      end else if (init_done_reg) begin
         if (re)
            ra_d_reg <= ra;
         if (ore) begin
            dout_reg     <= rd_word;
            dout_vld_reg <= 1'b1;
         end else begin
            dout_vld_reg <= 1'b0;
         end
      end else begin
         dout_vld_reg <= 1'b0;
      end
   end

   assign dout      = dout_reg;
   assign dout_vld  = dout_vld_reg;
   assign init_done = init_done_reg;

endmodule
